// File: rtl/pcg_rng_scheduler_pkg.sv
// Shared definitions for the PCG32 random-number scheduler: default LCG
// constants, the sequencing FSM encoding and the XSH-RR output permutation.
package pcg_pkg;

    localparam logic [63:0] PCG_MULT_DEFAULT = 64'h5851F42D4C957F2D;
    localparam logic [63:0] PCG_INC_DEFAULT  = 64'h14057B7EF767814F;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED0   = 3'd1,
        ST_SEED1   = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_PERMUTE = 3'd4,
        ST_DELIVER = 3'd5
    } pcg_state_t;

    // XSH-RR: xorshift the high bits down, then rotate by the top five bits.
    // A rotate amount of zero leaves the word untouched because the left
    // shift amount wraps to zero as well.
    function automatic logic [31:0] pcg_xsh_rr(input logic [63:0] old_state);
        logic [31:0] xs;
        logic [4:0]  rot;
        xs  = 32'(((old_state >> 18) ^ old_state) >> 27);
        rot = old_state[63:59];
        return (xs >> rot) | (xs << (5'd0 - rot));
    endfunction

endpackage

// File: rtl/pcg_rng_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, searching cyclically. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    // Scan from the farthest candidate back towards the pointer so the
    // candidate nearest the pointer is the last one written and wins.
    always_comb begin
        int              cand;
        logic [IDX_W-1:0] sel;
        cand      = 0;
        sel       = '0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            sel = IDX_W'(cand);
            if (req_i[sel]) begin
                gnt_o      = '0;
                gnt_o[sel] = 1'b1;
                gnt_idx_o  = sel;
            end
        end
    end

endmodule

// File: rtl/pcg_rng_scheduler.sv
// Shared PCG32 engine with round-robin delivery of 32-bit words to NUM_REQ
// requesters. One 64x64 multiplier serves both the reseed and advance steps.
//
// Handshake: req is a level; the granted requester sees a one-cycle one-hot
// ack pulse with rnd_data valid in that same cycle, and must drop req within
// one cycle of ack. A grant can not be cancelled once taken.
module pcg_rng_scheduler
    import pcg_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter logic [63:0] MULT        = PCG_MULT_DEFAULT,
    parameter logic [63:0] INC         = PCG_INC_DEFAULT,
    parameter logic [63:0] RESET_STATE = 64'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic [31:0]        rnd_data,
    input  logic               seed_load,
    input  logic [63:0]        seed_value,
    output logic               busy,
    output pcg_state_t         dbg_fsm_o,
    output logic [63:0]        dbg_lcg_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    pcg_state_t         fsm_q, fsm_d;
    logic [63:0]        lcg_q, lcg_d;
    logic [63:0]        perm_src_q, perm_src_d;
    logic [31:0]        out_q, out_d;
    logic [63:0]        seed_reg_q, seed_reg_d;
    logic               seed_pend_q, seed_pend_d;
    logic [63:0]        pend_val_q, pend_val_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [63:0]        mul_in;
    logic [63:0]        step_out;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i     (req),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    // The single LCG step: SEED1 folds the seed in, ADVANCE steps plainly.
    assign mul_in   = (fsm_q == ST_SEED1) ? (lcg_q + seed_reg_q) : lcg_q;
    assign step_out = mul_in * MULT + INC;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic: a reseed always beats a waiting request.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (seed_pend_q || seed_load) begin
                    fsm_d = ST_SEED0;
                end else if (|arb_gnt) begin
                    fsm_d = ST_ADVANCE;
                end
            end
            ST_SEED0:   fsm_d = ST_SEED1;
            ST_SEED1:   fsm_d = ST_IDLE;
            ST_ADVANCE: fsm_d = ST_PERMUTE;
            ST_PERMUTE: fsm_d = ST_DELIVER;
            ST_DELIVER: fsm_d = ST_IDLE;
            default:    fsm_d = ST_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcg_q       <= RESET_STATE;
            perm_src_q  <= '0;
            out_q       <= '0;
            seed_reg_q  <= '0;
            seed_pend_q <= 1'b0;
            pend_val_q  <= '0;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
        end else begin
            lcg_q       <= lcg_d;
            perm_src_q  <= perm_src_d;
            out_q       <= out_d;
            seed_reg_q  <= seed_reg_d;
            seed_pend_q <= seed_pend_d;
            pend_val_q  <= pend_val_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
        end
    end

    // Datapath next values. The pending seed is consumed when it is copied
    // into seed_reg, so a load arriving during SEED0/SEED1 queues another
    // reseed rather than being dropped.
    always_comb begin
        lcg_d       = lcg_q;
        perm_src_d  = perm_src_q;
        out_d       = out_q;
        seed_reg_d  = seed_reg_q;
        seed_pend_d = seed_pend_q;
        pend_val_d  = pend_val_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;

        if (fsm_q != ST_IDLE && seed_load) begin
            seed_pend_d = 1'b1;
            pend_val_d  = seed_value;
        end

        case (fsm_q)
            ST_IDLE: begin
                if (seed_pend_q || seed_load) begin
                    seed_reg_d  = seed_pend_q ? pend_val_q : seed_value;
                    seed_pend_d = 1'b0;
                end else if (|arb_gnt) begin
                    gnt_idx_d = arb_idx;
                end
            end
            ST_SEED0: lcg_d = INC;
            ST_SEED1: lcg_d = step_out;
            ST_ADVANCE: begin
                perm_src_d = lcg_q;
                lcg_d      = step_out;
            end
            ST_PERMUTE: out_d = pcg_xsh_rr(perm_src_q);
            ST_DELIVER: begin
                rr_ptr_d = (int'(gnt_idx_q) == NUM_REQ - 1) ? '0 : gnt_idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    // Outputs: ack and data only in DELIVER, busy everywhere but IDLE.
    always_comb begin
        ack       = '0;
        rnd_data  = '0;
        busy      = (fsm_q != ST_IDLE);
        dbg_fsm_o = fsm_q;
        dbg_lcg_o = lcg_q;
        if (fsm_q == ST_DELIVER) begin
            ack[gnt_idx_q] = 1'b1;
            rnd_data       = out_q;
        end
    end

endmodule

// File: tb/tb_pcg_rng_scheduler.sv
// Self-checking bench for pcg_rng_scheduler. The increment is set to the
// pcg32 stream 54 value, (54 << 1) | 1, so the seed-42 reference words apply.
module tb_pcg_rng_scheduler;
  import pcg_pkg::*;

  localparam int          NR     = 4;
  localparam logic [63:0] T_MULT = 64'h5851F42D4C957F2D;
  localparam logic [63:0] T_INC  = 64'h000000000000006D;
  localparam logic [63:0] T_RST  = 64'h0;

  typedef struct {
    logic [NR-1:0] mask;
    int            grant;
  } arb_vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] ack;
  logic [31:0]   rnd_data;
  logic          seed_load = 1'b0;
  logic [63:0]   seed_value = '0;
  logic          busy;
  pcg_state_t    dbg_fsm;
  logic [63:0]   dbg_lcg;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  logic [63:0] m_state = T_RST;
  int          m_ptr = 0;

  pcg_rng_scheduler #(
    .NUM_REQ     (NR),
    .MULT        (T_MULT),
    .INC         (T_INC),
    .RESET_STATE (T_RST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .rnd_data   (rnd_data),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .busy       (busy),
    .dbg_fsm_o  (dbg_fsm),
    .dbg_lcg_o  (dbg_lcg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  // reference model: plain pcg32 arithmetic
  function automatic logic [63:0] m_step(input logic [63:0] s);
    return s * T_MULT + T_INC;
  endfunction

  function automatic logic [31:0] m_output(input logic [63:0] s);
    logic [31:0] x;
    logic [63:0] doubled;
    int r;
    x = 32'((s ^ (s >> 18)) >> 27);
    r = int'(s >> 59);
    doubled = {x, x};
    return 32'(doubled >> r);
  endfunction

  function automatic logic [31:0] m_next_word();
    logic [31:0] w;
    w = m_output(m_state);
    m_state = m_step(m_state);
    return w;
  endfunction

  function automatic void m_reseed(input logic [63:0] seed);
    m_state = m_step(m_step(64'h0) + seed);
  endfunction

  function automatic int m_grant(input logic [NR-1:0] mask);
    for (int k = 0; k < NR; k++) begin
      if (mask[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard: every ack pops one expected word
  always @(negedge clk) begin
    if (ack !== '0) begin
      check("ack_onehot", 64'($countones(ack)), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'(ack), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rnd_data", 64'(rnd_data), 64'(mon_exp));
      end
    end else begin
      check("data_zero_without_ack", 64'(rnd_data), 64'd0);
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    req = '0;
    seed_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_state = T_RST;
    m_ptr = 0;
  endtask

  task automatic wait_ack(output int lat, output logic [NR-1:0] a, output logic [31:0] d);
    lat = 0;
    a = '0;
    d = '0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack !== '0) begin
        lat = n;
        a = ack;
        d = rnd_data;
        break;
      end
    end
  endtask

  task automatic start_req(input logic [NR-1:0] mask, input int forced_grant, output int g);
    g = (forced_grant >= 0) ? forced_grant : m_grant(mask);
    exp_q.push_back(m_next_word());
    m_ptr = (g + 1) % NR;
    @(posedge clk);
    #1 req = mask;
  endtask

  task automatic transact(input string name, input logic [NR-1:0] mask, input int forced_grant,
                          output logic [31:0] d);
    int g;
    int lat;
    logic [NR-1:0] a;
    start_req(mask, forced_grant, g);
    wait_ack(lat, a, d);
    req = '0;
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_grant"}, 64'(a), 64'(1) << g);
  endtask

  task automatic check_seq_state(input string name, input pcg_state_t st);
    check({name, "_state"}, 64'(dbg_fsm), 64'(st));
    check({name, "_busy"}, 64'(busy), (st == ST_IDLE) ? 64'd0 : 64'd1);
  endtask

  task automatic pulse_seed_idle(input logic [63:0] sv);
    @(posedge clk);
    #1 seed_load = 1'b1;
    seed_value = sv;
    @(posedge clk);
    #1 seed_load = 1'b0;
    @(negedge clk) check_seq_state("seed0", ST_SEED0);
    @(posedge clk);
    @(negedge clk) check_seq_state("seed1", ST_SEED1);
    @(posedge clk);
    @(negedge clk) check_seq_state("seed_done", ST_IDLE);
    m_reseed(sv);
  endtask

  // after an in-flight ack with a pending seed: IDLE, SEED0, SEED1, IDLE
  task automatic walk_pending_reseed(input logic [63:0] sv);
    @(posedge clk);
    @(negedge clk) check_seq_state("pend_idle", ST_IDLE);
    @(posedge clk);
    @(negedge clk) check_seq_state("pend_seed0", ST_SEED0);
    @(posedge clk);
    @(negedge clk) check_seq_state("pend_seed1", ST_SEED1);
    @(posedge clk);
    @(negedge clk) check_seq_state("pend_done", ST_IDLE);
    m_reseed(sv);
  endtask

  // main sequence
  initial begin
    arb_vec_t vecs[10];
    logic [31:0] golden[3];
    logic [31:0] d;
    logic [NR-1:0] a;
    int lat;
    int g;

    vecs[0] = '{4'b0001, 0};
    vecs[1] = '{4'b0001, 0};
    vecs[2] = '{4'b1010, 1};
    vecs[3] = '{4'b1010, 3};
    vecs[4] = '{4'b0100, 2};
    vecs[5] = '{4'b0011, 0};
    vecs[6] = '{4'b1100, 2};
    vecs[7] = '{4'b1111, 3};
    vecs[8] = '{4'b1111, 0};
    vecs[9] = '{4'b1000, 3};
    golden[0] = 32'hA15C02B7;
    golden[1] = 32'h7B47F409;
    golden[2] = 32'hBA1D3330;

    // reset values
    do_reset();
    @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_data", 64'(rnd_data), 64'd0);
    check_seq_state("rst", ST_IDLE);
    check("rst_lcg", dbg_lcg, T_RST);

    // req[0] held: first word from state 0, second from state INC
    start_req(4'b0001, -1, g);
    exp_q.push_back(m_next_word());
    m_ptr = 1;
    wait_ack(lat, a, d);
    check("held_first_latency", 64'(lat), 64'd3);
    check("held_first_ack", 64'(a), 64'b0001);
    check("held_first_word", 64'(d), 64'h0);
    wait_ack(lat, a, d);
    req = '0;
    check("held_second_latency", 64'(lat), 64'd4);
    check("held_second_ack", 64'(a), 64'b0001);

    // arbitration table from a fresh pointer
    do_reset();
    for (int i = 0; i < 10; i++) begin
      transact($sformatf("arb_vec%0d", i), vecs[i].mask, vecs[i].grant, d);
    end

    // fairness with everyone requesting
    do_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back(m_next_word());
    @(posedge clk);
    #1 req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      wait_ack(lat, a, d);
      check($sformatf("fair%0d_latency", i), 64'(lat), (i == 0) ? 64'd3 : 64'd4);
      check($sformatf("fair%0d_ack", i), 64'(a), 64'(1) << (i % NR));
    end
    req = '0;
    m_ptr = 0;

    // clean reseed with 42 reproduces the pcg32 reference stream
    do_reset();
    pulse_seed_idle(64'd42);
    for (int i = 0; i < 3; i++) begin
      transact($sformatf("seed42_w%0d", i), 4'b0010, -1, d);
      check($sformatf("seed42_golden%0d", i), 64'(d), 64'(golden[i]));
    end

    // seed_load during PERMUTE: in-flight word is pre-seed
    start_req(4'b0001, -1, g);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) check_seq_state("inflight_permute", ST_PERMUTE);
    #1 seed_load = 1'b1;
    seed_value = 64'd42;
    @(posedge clk);
    #1 seed_load = 1'b0;
    @(negedge clk);
    check("inflight_ack", 64'(ack), 64'(1) << g);
    req = '0;
    walk_pending_reseed(64'd42);
    transact("after_inflight", 4'b0100, -1, d);
    check("after_inflight_golden", 64'(d), 64'(golden[0]));

    // two loads while busy: last one wins
    start_req(4'b0010, -1, g);
    @(posedge clk);
    #1 seed_load = 1'b1;
    seed_value = 64'd5;
    @(posedge clk);
    #1 seed_value = 64'd42;
    @(posedge clk);
    #1 seed_load = 1'b0;
    @(negedge clk);
    check("double_inflight_ack", 64'(ack), 64'(1) << g);
    req = '0;
    walk_pending_reseed(64'd42);
    for (int i = 0; i < 3; i++) begin
      transact($sformatf("double_w%0d", i), 4'b0010, -1, d);
      check($sformatf("double_golden%0d", i), 64'(d), 64'(golden[i]));
    end

    // reset during PERMUTE: no ack, state back to reset value
    @(posedge clk);
    #1 req = 4'b0100;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("midrst_ack", 64'(ack), 64'd0);
    check("midrst_lcg", dbg_lcg, T_RST);
    check_seq_state("midrst", ST_IDLE);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_state = T_RST;
    m_ptr = 0;
    transact("after_rst", 4'b0001, -1, d);
    check("after_rst_word", 64'(d), 64'h0);

    // randomized traffic with occasional reseeds
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        pulse_seed_idle({32'($urandom), 32'($urandom)});
      end
      transact("rand", 4'($urandom_range(1, 15)), -1, d);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
